// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch controller states: one idle cycle after reset, normal fetch, terminal fault.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Byte distance between consecutive instruction words.
    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection.
// Priority: reset, then redirect load, then sequential advance, else hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_pc,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_pc
);

    logic [WIDTH-1:0] r_pc;

    // PC update; the +4 wraps naturally modulo 2**WIDTH.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_advance) begin
            r_pc <= r_pc + WIDTH'(PC_STEP);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the imem word address from the PC, registers the
// returned word into the IF/ID register and handles redirects and misaligned-target faults.
//
// Handshake toward decode: valid_out/instr_out/pc_out are registers. A transfer happens on
// an edge where valid_out && ready_in. While valid_out && !ready_in the outputs are frozen.
// A new word is captured whenever the register is empty or being drained (!valid_out ||
// ready_in); a redirect in FETCH overrides this and empties the register instead.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               INDEX    = 5,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic [INDEX-1:0] imem_addr_out,
    input  logic [WIDTH-1:0] imem_data_in,
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             fault_out,
    output fetch_state_t     state_out
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic             r_valid;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc_out;
    logic [WIDTH-1:0] w_pc;
    logic             w_adv;
    logic             w_load;
    logic             w_squash;

    fetch_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_load    (w_load),
        .i_load_pc (redirect_pc_in),
        .i_advance (w_adv),
        .o_pc      (w_pc)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the capture/load/squash controls for this cycle.
    always_comb begin
        w_state_next = r_state;
        w_adv        = 1'b0;
        w_load       = 1'b0;
        w_squash     = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (redirect_in) begin
                    w_squash = 1'b1;
                    if (redirect_pc_in[1:0] == 2'b00) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = FAULT;
                    end
                end else begin
                    w_adv = !r_valid || ready_in;
                end
            end
            FAULT: begin
                w_squash = 1'b1;
            end
            default: begin
                w_state_next = BOOT;
                w_squash     = 1'b1;
            end
        endcase
    end

    // IF/ID register: capture on advance, empty on redirect or fault, otherwise hold.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_pc_out <= '0;
        end else if (w_adv) begin
            r_valid  <= 1'b1;
            r_instr  <= imem_data_in;
            r_pc_out <= w_pc;
        end else if (w_squash) begin
            r_valid  <= 1'b0;
        end
    end

    assign imem_addr_out = w_pc[INDEX+1:2];
    assign valid_out     = r_valid;
    assign instr_out     = r_instr;
    assign pc_out        = r_pc_out;
    assign fault_out     = (r_state == FAULT);
    assign state_out     = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle-level reference model of the fetch rules, a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_fetch_stage;
    import fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rd  = 1'b0;
    logic [31:0] rpc = 32'h0;

    // ---------------- DUT A (RESET_PC = 0) ----------------
    logic [4:0]   addr_a;
    logic [31:0]  data_a;
    logic         valid_a;
    logic [31:0]  instr_a;
    logic [31:0]  pcout_a;
    logic         fault_a;
    fetch_state_t state_a;

    assign data_a = 32'hA000_0000 + 32'(addr_a);

    fetch_stage #(.WIDTH(32), .INDEX(5), .RESET_PC(32'h0)) u_dut (
        .clk_in(clk), .rst_in(rst), .imem_addr_out(addr_a), .imem_data_in(data_a),
        .redirect_in(rd), .redirect_pc_in(rpc), .ready_in(rdy), .valid_out(valid_a),
        .instr_out(instr_a), .pc_out(pcout_a), .fault_out(fault_a), .state_out(state_a)
    );

    // ---------------- DUT B (RESET_PC = 0x7C, wrap of imem depth) ----------------
    logic [4:0]   addr_b;
    logic [31:0]  data_b;
    logic         valid_b;
    logic [31:0]  instr_b;
    logic [31:0]  pcout_b;
    logic         fault_b;
    fetch_state_t state_b;
    logic         rdy_b = 1'b1;
    logic         rd_b  = 1'b0;
    logic [31:0]  rpc_b = 32'h0;

    assign data_b = 32'hA000_0000 + 32'(addr_b);

    fetch_stage #(.WIDTH(32), .INDEX(5), .RESET_PC(32'h7C)) u_wrap (
        .clk_in(clk), .rst_in(rst), .imem_addr_out(addr_b), .imem_data_in(data_b),
        .redirect_in(rd_b), .redirect_pc_in(rpc_b), .ready_in(rdy_b), .valid_out(valid_b),
        .instr_out(instr_b), .pc_out(pcout_b), .fault_out(fault_b), .state_out(state_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model for DUT A ----------------
    // Word stored at a byte address in the preloaded imem (32 words, upper bits alias).
    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return 32'hA000_0000 + ((byte_addr >> 2) % 32);
    endfunction

    // Model phases: 0 = idle after reset, 1 = fetching, 2 = faulted.
    int          m_phase = 0;
    logic [31:0] m_pc    = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pcout = 32'h0;
    logic        chk_en  = 1'b0;

    // Advance the model by one clock edge using the inputs presented before it.
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pcout = 32'h0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (rd) begin
                m_valid = 1'b0;
                if (rpc % 4 == 0) m_pc = rpc;
                else m_phase = 2;
            end else if (!m_valid || rdy) begin
                m_instr = mem_word(m_pc);
                m_pcout = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else begin
            m_valid = 1'b0;
        end
    end

    // Compare DUT A against the model every cycle, half a period after the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_valid", 32'(valid_a), 32'(m_valid));
            check("cmp_fault", 32'(fault_a), 32'(m_phase == 2));
            check("cmp_addr",  32'(addr_a),  (m_pc >> 2) % 32);
            if (m_valid || m_phase == 0) begin
                check("cmp_instr", instr_a, m_instr);
                check("cmp_pcout", pcout_a, m_pcout);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic rd_v, input logic rdyv, input logic [31:0] p);
        #1;
        rst = r; rd = rd_v; rdy = rdyv; rpc = p;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc);
        check({name, "_valid"}, 32'(valid_a), 32'(v));
        check({name, "_instr"}, instr_a, ins);
        check({name, "_pc"},    pcout_a, pc);
    endtask

    // ---------------- directed scenarios ----------------
    logic [15:0] rdy_pattern = 16'b1011_0010_1110_0101;

    initial begin
        // Reset held over two edges.
        tick();
        tick();
        expect_out("rst", 1'b0, 32'h0, 32'h0);
        check("rst_fault", 32'(fault_a), 32'h0);
        check("rst_addr", 32'(addr_a), 32'h0);
        check("wrap_rst_addr", 32'(addr_b), 32'h1F);
        chk_en = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 32'h0);

        // 1. Boot cycle then streaming fetch.
        tick();
        check("boot_valid", 32'(valid_a), 32'h0);
        check("wrap_boot_valid", 32'(valid_b), 32'h0);
        tick();
        expect_out("s0", 1'b1, 32'hA000_0000, 32'h0);
        check("wrap_instr0", instr_b, 32'hA000_001F);
        check("wrap_pc0", pcout_b, 32'h7C);
        tick();
        expect_out("s1", 1'b1, 32'hA000_0001, 32'h4);
        check("wrap_instr1", instr_b, 32'hA000_0000);
        check("wrap_pc1", pcout_b, 32'h80);
        tick();
        expect_out("s2", 1'b1, 32'hA000_0002, 32'h8);

        // 2. Stall three cycles: outputs frozen, address parked on the next word.
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall", 1'b1, 32'hA000_0002, 32'h8);
            check("stall_addr", 32'(addr_a), 32'h3);
        end
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        expect_out("release", 1'b1, 32'hA000_0003, 32'hC);

        // 3. Redirect to 0x40 while decode is stalled.
        set_in(1'b0, 1'b1, 1'b0, 32'h40);
        tick();
        check("redir_squash", 32'(valid_a), 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        expect_out("redir_tgt", 1'b1, 32'hA000_0010, 32'h40);

        // Back-to-back redirects: the last one wins.
        set_in(1'b0, 1'b1, 1'b1, 32'h20);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 32'h60);
        tick();
        check("b2b_valid", 32'(valid_a), 32'h0);
        check("b2b_addr", 32'(addr_a), 32'h18);
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        expect_out("b2b_tgt", 1'b1, 32'hA000_0018, 32'h60);

        // 6. Reset in the middle of a stall.
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("pre_rst_valid", 32'(valid_a), 32'h1);
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        expect_out("mid_rst", 1'b0, 32'h0, 32'h0);
        check("mid_rst_addr", 32'(addr_a), 32'h0);
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        tick();
        expect_out("restart", 1'b1, 32'hA000_0000, 32'h0);

        // 5. Misaligned redirect: sticky fault, redirects ignored, only reset clears it.
        set_in(1'b0, 1'b1, 1'b1, 32'h42);
        tick();
        check("fault_set", 32'(fault_a), 32'h1);
        check("fault_valid", 32'(valid_a), 32'h0);
        check("fault_addr", 32'(addr_a), 32'h1);
        check("fault_state", 32'(state_a), 32'(FAULT));
        set_in(1'b0, 1'b1, 1'b1, 32'h40);
        tick();
        check("fault_redir_ign", 32'(addr_a), 32'h1);
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("fault_sticky", 32'(fault_a), 32'h1);
        end
        set_in(1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        check("fault_clear", 32'(fault_a), 32'h0);
        // Redirect presented during the boot cycle is ignored.
        set_in(1'b0, 1'b1, 1'b1, 32'h40);
        tick();
        check("boot2_valid", 32'(valid_a), 32'h0);
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        expect_out("boot_redir_ign", 1'b1, 32'hA000_0000, 32'h0);

        // Full-width PC wrap.
        set_in(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        expect_out("top_0", 1'b1, 32'hA000_001E, 32'hFFFF_FFF8);
        tick();
        expect_out("top_1", 1'b1, 32'hA000_001F, 32'hFFFF_FFFC);
        tick();
        expect_out("top_2", 1'b1, 32'hA000_0000, 32'h0);

        // Fixed ready pattern, checked by the model alone.
        for (int i = 0; i < 16; i++) begin
            set_in(1'b0, 1'b0, rdy_pattern[i], 32'h0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
